// File: rtl/simon_pkg.sv
// Shared definitions for the Simon game controller: state encoding,
// mode LED patterns and memory geometry.
package simon_pkg;

  localparam int MEM_DEPTH = 64;
  localparam int AW        = 6;
  localparam int SEQ_W     = 7;

  typedef enum logic [1:0] {
    ST_INPUT    = 2'd0,
    ST_PLAYBACK = 2'd1,
    ST_REPEAT   = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  localparam logic [2:0] LED_MODE_INPUT    = 3'b001;
  localparam logic [2:0] LED_MODE_PLAYBACK = 3'b010;
  localparam logic [2:0] LED_MODE_REPEAT   = 3'b100;
  localparam logic [2:0] LED_MODE_DONE     = 3'b111;

  function automatic logic [2:0] mode_leds_of(input state_t s);
    logic [2:0] m;
    m = LED_MODE_INPUT;
    case (s)
      ST_INPUT:    m = LED_MODE_INPUT;
      ST_PLAYBACK: m = LED_MODE_PLAYBACK;
      ST_REPEAT:   m = LED_MODE_REPEAT;
      ST_DONE:     m = LED_MODE_DONE;
      default:     m = LED_MODE_INPUT;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/simon_pattern_check.sv
// Combinational pattern checks: legality of a new entry under the active
// difficulty, and equality of a guess with the stored entry.
module simon_pattern_check (
  input  logic [3:0] pattern,
  input  logic [3:0] mem_rdata,
  input  logic       level_eff,
  output logic       legal,
  output logic       match
);

  logic one_hot;

  // Easy mode accepts exactly one lit switch.
  assign one_hot = (pattern != 4'd0) && ((pattern & (pattern - 4'd1)) == 4'd0);
  assign legal   = level_eff | one_hot;
  assign match   = (pattern == mem_rdata);

endmodule

// File: rtl/simon_ctrl.sv
// Simon game control unit: owns mode, sequence length, play/guess index and
// the latched difficulty; drives the pattern memory port and LEDs.
module simon_ctrl
  import simon_pkg::*;
(
  input  logic          pclk,
  input  logic          rst,
  input  logic          level,
  input  logic [3:0]    pattern,
  input  logic [3:0]    mem_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [3:0]    mem_wdata,
  output logic [3:0]    pattern_leds,
  output logic [2:0]    mode_leds
);

  state_t             state_q, state_d;
  logic [SEQ_W-1:0]   seq_len_q, seq_len_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic               level_q, level_d;

  logic               level_eff;
  logic               legal;
  logic               match;
  logic               last;

  // Difficulty is taken live only until the first entry is stored.
  assign level_eff = (seq_len_q == '0) ? level : level_q;
  assign last      = ({1'b0, idx_q} == (seq_len_q - SEQ_W'(1)));

  simon_pattern_check u_check (
    .pattern   (pattern),
    .mem_rdata (mem_rdata),
    .level_eff (level_eff),
    .legal     (legal),
    .match     (match)
  );

  always_comb begin
    state_d   = state_q;
    seq_len_d = seq_len_q;
    idx_d     = idx_q;
    level_d   = level_q;
    case (state_q)
      ST_INPUT: begin
        if (legal) begin
          seq_len_d = seq_len_q + SEQ_W'(1);
          idx_d     = '0;
          state_d   = ST_PLAYBACK;
          if (seq_len_q == '0) level_d = level;
        end
      end
      ST_PLAYBACK: begin
        if (last) begin
          state_d = ST_REPEAT;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      ST_REPEAT: begin
        if (!match) begin
          state_d = ST_DONE;
          idx_d   = '0;
        end else if (last) begin
          idx_d   = '0;
          state_d = (seq_len_q == SEQ_W'(MEM_DEPTH)) ? ST_DONE : ST_INPUT;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      ST_DONE: begin
        idx_d = last ? '0 : idx_q + AW'(1);
      end
      default: begin
        state_d = ST_INPUT;
      end
    endcase
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_INPUT;
      seq_len_q <= '0;
      idx_q     <= '0;
      level_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      seq_len_q <= seq_len_d;
      idx_q     <= idx_d;
      level_q   <= level_d;
    end
  end

  // INPUT addresses the next free slot; every other mode walks idx.
  always_comb begin
    mem_wdata    = pattern;
    mem_addr     = idx_q;
    pattern_leds = mem_rdata;
    mem_we       = 1'b0;
    mode_leds    = mode_leds_of(state_q);
    case (state_q)
      ST_INPUT: begin
        mem_addr     = seq_len_q[AW-1:0];
        pattern_leds = pattern;
        mem_we       = legal & ~rst;
      end
      ST_REPEAT: begin
        pattern_leds = pattern;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_simon_ctrl.sv
// Directed bench for simon_ctrl with a behavioural pattern memory attached.
module tb_simon_ctrl;

  logic       pclk;
  logic       rst;
  logic       level;
  logic [3:0] pattern;
  logic [3:0] mem_rdata;
  logic [5:0] mem_addr;
  logic       mem_we;
  logic [3:0] mem_wdata;
  logic [3:0] pattern_leds;
  logic [2:0] mode_leds;

  logic [3:0] mem [64];

  int tests = 0;
  int fails = 0;

  simon_ctrl dut (
    .pclk         (pclk),
    .rst          (rst),
    .level        (level),
    .pattern      (pattern),
    .mem_rdata    (mem_rdata),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .pattern_leds (pattern_leds),
    .mode_leds    (mode_leds)
  );

  assign mem_rdata = mem[mem_addr];

  always @(posedge pclk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1);
  end

  typedef struct {
    logic [3:0] pat;
    logic       lvl;
    logic [2:0] mode;
    logic [3:0] leds;
    logic       we;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic do_reset(input logic lvl, input logic [3:0] pat);
    level   = lvl;
    pattern = pat;
    rst     = 1'b1;
    #1;
    chk("rst_mode", {29'd0, mode_leds}, 32'h1);
    chk("rst_we", {31'd0, mem_we}, 32'h0);
    chk("rst_leds", {28'd0, pattern_leds}, {28'd0, pat});
    step();
    rst = 1'b0;
    #1;
  endtask

  logic [3:0] seqv [64];

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 4'd0;
    rst     = 1'b1;
    level   = 1'b1;
    pattern = 4'd0;

    // pat, level, mode after edge, leds after edge, mem_we after edge
    vecs[0]  = '{4'b0011, 1'b1, 3'b010, 4'b0011, 1'b0};
    vecs[1]  = '{4'b0011, 1'b1, 3'b100, 4'b0011, 1'b0};
    vecs[2]  = '{4'b0011, 1'b1, 3'b001, 4'b0011, 1'b1};
    vecs[3]  = '{4'b1010, 1'b0, 3'b010, 4'b0011, 1'b0};
    vecs[4]  = '{4'b1010, 1'b0, 3'b010, 4'b1010, 1'b0};
    vecs[5]  = '{4'b0011, 1'b0, 3'b100, 4'b0011, 1'b0};
    vecs[6]  = '{4'b0011, 1'b0, 3'b100, 4'b0011, 1'b0};
    vecs[7]  = '{4'b1010, 1'b0, 3'b001, 4'b1010, 1'b1};
    vecs[8]  = '{4'b1101, 1'b0, 3'b010, 4'b0011, 1'b0};
    vecs[9]  = '{4'b1101, 1'b0, 3'b010, 4'b1010, 1'b0};
    vecs[10] = '{4'b1101, 1'b0, 3'b010, 4'b1101, 1'b0};
    vecs[11] = '{4'b0011, 1'b0, 3'b100, 4'b0011, 1'b0};
    vecs[12] = '{4'b0011, 1'b0, 3'b100, 4'b0011, 1'b0};
    vecs[13] = '{4'b1110, 1'b0, 3'b111, 4'b0011, 1'b0};
    vecs[14] = '{4'b0000, 1'b0, 3'b111, 4'b1010, 1'b0};
    vecs[15] = '{4'b0000, 1'b0, 3'b111, 4'b1101, 1'b0};
    vecs[16] = '{4'b0000, 1'b0, 3'b111, 4'b0011, 1'b0};
    vecs[17] = '{4'b0000, 1'b0, 3'b111, 4'b1010, 1'b0};
    vecs[18] = '{4'b1111, 1'b0, 3'b111, 4'b1101, 1'b0};

    // Rounds 1-3, locked level, wrong guess and DONE wraparound.
    do_reset(1'b1, 4'b0011);
    chk("idle_we", {31'd0, mem_we}, 32'h1);
    for (int i = 0; i < 19; i++) begin
      pattern = vecs[i].pat;
      level   = vecs[i].lvl;
      step();
      chk($sformatf("vec%0d_mode", i), {29'd0, mode_leds}, {29'd0, vecs[i].mode});
      chk($sformatf("vec%0d_leds", i), {28'd0, pattern_leds}, {28'd0, vecs[i].leds});
      chk($sformatf("vec%0d_we", i), {31'd0, mem_we}, {31'd0, vecs[i].we});
    end

    // Easy-mode legality.
    do_reset(1'b0, 4'b0110);
    chk("easy_illegal_we", {31'd0, mem_we}, 32'h0);
    step();
    chk("easy_illegal_mode", {29'd0, mode_leds}, 32'h1);
    chk("easy_illegal_addr", {26'd0, mem_addr}, 32'h0);
    pattern = 4'b0100;
    #1;
    chk("easy_legal_we", {31'd0, mem_we}, 32'h1);
    step();
    chk("easy_legal_mode", {29'd0, mode_leds}, 32'h2);
    chk("easy_legal_leds", {28'd0, pattern_leds}, 32'h4);

    // Asynchronous reset in the middle of REPEAT, between clock edges.
    step();
    chk("pre_async_mode", {29'd0, mode_leds}, 32'h4);
    #3;
    rst = 1'b1;
    #1;
    chk("async_mode", {29'd0, mode_leds}, 32'h1);
    chk("async_addr", {26'd0, mem_addr}, 32'h0);
    chk("async_we", {31'd0, mem_we}, 32'h0);
    step();
    rst     = 1'b0;
    level   = 1'b0;
    pattern = 4'b0110;
    #1;
    chk("post_async_we", {31'd0, mem_we}, 32'h0);

    // Full 64-round win, then DONE playback over every entry.
    for (int i = 0; i < 64; i++) seqv[i] = 4'((i * 7 + 3) % 16);
    do_reset(1'b1, 4'b0000);
    for (int r = 0; r < 64; r++) begin
      pattern = seqv[r];
      step();
      chk($sformatf("win%0d_pb_mode", r), {29'd0, mode_leds}, 32'h2);
      chk($sformatf("win%0d_pb0", r), {28'd0, pattern_leds}, {28'd0, seqv[0]});
      for (int i = 1; i <= r; i++) begin
        step();
        chk($sformatf("win%0d_pb%0d", r, i), {28'd0, pattern_leds}, {28'd0, seqv[i]});
      end
      step();
      chk($sformatf("win%0d_rep_mode", r), {29'd0, mode_leds}, 32'h4);
      for (int i = 0; i <= r; i++) begin
        pattern = seqv[i];
        step();
      end
      chk($sformatf("win%0d_end_mode", r), {29'd0, mode_leds}, (r == 63) ? 32'h7 : 32'h1);
    end
    chk("done_leds0", {28'd0, pattern_leds}, {28'd0, seqv[0]});
    for (int k = 1; k <= 64; k++) begin
      step();
      chk($sformatf("done_leds%0d", k), {28'd0, pattern_leds}, {28'd0, seqv[k % 64]});
      chk($sformatf("done_mode%0d", k), {29'd0, mode_leds}, 32'h7);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/simon_ctrl.md
# simon_ctrl

Control unit for the Simon game. It sequences the 64-entry pattern memory and the LED outputs through the input, playback, repeat and done modes. It sits between the top-level switch inputs and the datapath memory. It owns all game state: mode, sequence length, playback/guess index and the latched difficulty level. The memory itself stays in the datapath.

## Interface
- MEM_DEPTH, 64: pattern memory entries; sequence length limit.
- AW, 6: memory address width, equal to log2(MEM_DEPTH).
- pclk  in  1  game clock; every user advance is one rising edge.
- rst  in  1  reset; asynchronous, active-high.
- level  in  1  difficulty: 1 = hard, 0 = easy. Sampled only for the first input of a game.
- pattern  in  4  switch inputs.
- mem_rdata  in  4  datapath memory read data; combinational from mem_addr.
- mem_addr  out  AW  memory address; shared by read and write.
- mem_we  out  1  memory write enable; write occurs on the rising edge of pclk.
- mem_wdata  out  4  write data; always equal to pattern.
- pattern_leds  out  4  pattern display.
- mode_leds  out  3  mode display: INPUT 001, PLAYBACK 010, REPEAT 100, DONE 111.

## Operation
- State registers:
  - state (2 bits)
  - seq_len (7 bits, range 0..64)
  - idx (AW bits)
  - level_q (1 bit)
- Effective level: level_eff = level when seq_len==0, otherwise level_q. Changing level mid-game has no effect.
- Legality of a pattern:
  - Hard: any 4-bit value.
  - Easy: exactly one bit set.
- INPUT:
  - Outputs: pattern_leds = pattern; mem_addr = seq_len[AW-1:0].
  - mem_we = legal(pattern) and not rst.
  - On an edge with a legal pattern: write memory, increment seq_len, set idx=0, go to PLAYBACK. If seq_len was 0, also load level_q from level.
  - On an edge with an illegal pattern: no write, no state change.
- PLAYBACK:
  - Outputs: mem_addr = idx; pattern_leds = mem_rdata; mem_we = 0.
  - On each edge: if idx == seq_len-1, go to REPEAT with idx=0. Otherwise increment idx.
- REPEAT:
  - Outputs: mem_addr = idx; pattern_leds = pattern; mem_we = 0.
  - On each edge, compare pattern against mem_rdata:
    - Mismatch: go to DONE, idx=0.
    - Match at idx == seq_len-1: idx=0; go to DONE if seq_len == MEM_DEPTH (win), otherwise go to INPUT.
    - Match otherwise: increment idx.
- DONE:
  - Outputs: mem_addr = idx; pattern_leds = mem_rdata; mem_we = 0.
  - On each edge, idx advances and wraps from seq_len-1 to 0.
  - Only reset exits DONE.
- Width rules:
  - seq_len is 7 bits, so the full value 64 is representable.
  - seq_len-1 is computed at 7 bits and compared with idx zero-extended to 7 bits.

## Timing
- Reset values: state=INPUT, seq_len=0, idx=0, level_q=0.
  - Therefore mode_leds=001, pattern_leds follows pattern, and mem_we=0 while rst is high.
- Reset mid-operation: all registers clear immediately, regardless of the current state.
- All outputs are combinational from registered state plus pattern and mem_rdata. The outputs settle after the same edge, with no extra latency.
- Memory write, mode transition and index update take effect on the same edge. After the edge, a PLAYBACK read of address 0 already sees the newly written entry.
- A single-entry sequence spends exactly one edge in PLAYBACK.
- An entry is never written while seq_len == MEM_DEPTH, because INPUT is unreachable at that length.

## Structure
- Shared package simon_pkg holds:
  - The state encoding: INPUT, PLAYBACK, REPEAT, DONE.
  - The LED_MODE_* constants.
  - MEM_DEPTH.
- One sub-module, simon_pattern_check, which is purely combinational:
  - Inputs: pattern, mem_rdata, level_eff.
  - Outputs: legal, match.
- Everything else is a single always block for the registers plus combinational output muxing.

## Test plan
- Reset, start game, first round:
  - Stimulus: level=1, pulse rst, then pattern=0011 and one edge.
  - Response: mode goes 001 -> 010 and pattern_leds=0011. One more edge gives mode 100. pattern=0011 plus an edge gives mode 001.
- Level locked and multi-entry playback:
  - Stimulus: after round 1, set level=0 and pattern=1010 (illegal in easy mode, accepted because level_q=1), then an edge.
  - Response: playback shows 0011 then 1010, then the mode goes to REPEAT.
- Wrong guess and DONE wraparound:
  - Stimulus: sequence 0011/1010/1101; in REPEAT, guess 0011 then 1110.
  - Response: mode goes to 111. pattern_leds cycles 0011, 1010, 1101, 0011, 1010 on successive edges. mode_leds stays 111.
- Easy-mode legality:
  - Stimulus: level=0, reset, pattern=0110 and an edge.
  - Response: mode stays 001 and mem_we=0. Then pattern=0100 and an edge gives mode 010.
- Async reset mid-game:
  - Stimulus: assert rst in the middle of REPEAT, between edges.
  - Response: mode_leds=001 immediately, with no clock; seq_len=0.
- Full sequence win:
  - Stimulus: 64 rounds, all correct.
  - Response: after the 64th correct repeat the mode is 111, and DONE playback cycles through all 64 entries.
